// File: rtl/spi_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_cmd_master
//  Purpose  : SPI initiator (CPOL=0, CPHA=1) for the register-access SPI
//             slave. Each accepted request issues one frame, MSB first:
//               write : {0, addr[6:0]}, wdata                  (16 bits)
//               read  : {1, addr[6:0]}, 0x00 dummy, data byte  (24 bits)
//  Ports    : clk    in   system clock, rising edge
//             rst    in   synchronous active-high reset
//             start  in   request pulse, accepted only while busy=0
//             rw     in   1=read, 0=write (latched on accept)
//             addr   in   7-bit register address (latched on accept)
//             wdata  in   write data (latched on accept, unused for reads)
//             busy   out  high from cycle after accept to end of CS gap
//             done   out  one-cycle pulse as cs returns high
//             rdata  out  read result, updated only when a read completes
//             sclk   out  SPI clock, idles low
//             mosi   out  SPI data out, changes on sclk rising edges
//             cs     out  chip select, active low
//             miso   in   SPI data in, sampled on sclk falling edges
//  Revision : 1.0  initial release
// ============================================================================
module spi_cmd_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       mosi,
    output logic       cs,
    input  logic       miso
);

    localparam int c_HC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_GAP_W = $clog2(2 * CLK_DIV);

    localparam logic [c_HC_W-1:0]  c_HC_LAST  = c_HC_W'(CLK_DIV - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(2 * CLK_DIV - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
    localparam logic [2:0] c_ST_HOLD  = 3'd3;
    localparam logic [2:0] c_ST_GAP   = 3'd4;

    logic [2:0]         r_state;
    logic [c_HC_W-1:0]  r_hc;
    logic [c_GAP_W-1:0] r_gap;
    logic [4:0]         r_bit_cnt;
    logic [23:0]        r_sr;
    logic [7:0]         r_rx;
    logic               r_rw;
    logic               r_busy;
    logic               r_done;
    logic [7:0]         r_rdata;
    logic               r_sclk;
    logic               r_mosi;
    logic               r_cs;

    logic [4:0]         w_last_bit;

    assign w_last_bit = r_rw ? 5'd23 : 5'd15;

    assign busy  = r_busy;
    assign done  = r_done;
    assign rdata = r_rdata;
    assign sclk  = r_sclk;
    assign mosi  = r_mosi;
    assign cs    = r_cs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_hc      <= '0;
            r_gap     <= '0;
            r_bit_cnt <= '0;
            r_sr      <= '0;
            r_rx      <= '0;
            r_rw      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs      <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        // Frame is left-aligned in the shift register; a read
                        // shifts out zeros for the dummy and data bytes.
                        r_rw    <= rw;
                        r_sr    <= {rw, addr, (rw ? 8'h00 : wdata), 8'h00};
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_hc    <= '0;
                        r_state <= c_ST_SETUP;
                    end
                end

                c_ST_SETUP: begin
                    if (r_hc == c_HC_LAST) begin
                        r_hc      <= '0;
                        r_bit_cnt <= '0;
                        r_sclk    <= 1'b1;
                        r_mosi    <= r_sr[23];
                        r_sr      <= {r_sr[22:0], 1'b0};
                        r_state   <= c_ST_SHIFT;
                    end else begin
                        r_hc <= r_hc + 1'b1;
                    end
                end

                c_ST_SHIFT: begin
                    if (r_hc == c_HC_LAST) begin
                        r_hc <= '0;
                        if (r_sclk) begin
                            // End of high phase: falling edge, capture miso.
                            r_sclk <= 1'b0;
                            r_rx   <= {r_rx[6:0], miso};
                        end else if (r_bit_cnt == w_last_bit) begin
                            r_state <= c_ST_HOLD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_sclk    <= 1'b1;
                            r_mosi    <= r_sr[23];
                            r_sr      <= {r_sr[22:0], 1'b0};
                        end
                    end else begin
                        r_hc <= r_hc + 1'b1;
                    end
                end

                c_ST_HOLD: begin
                    if (r_hc == c_HC_LAST) begin
                        r_hc    <= '0;
                        r_cs    <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_done  <= 1'b1;
                        r_gap   <= '0;
                        r_state <= c_ST_GAP;
                        // Only the final eight samples (data byte) are kept.
                        if (r_rw) begin
                            r_rdata <= r_rx;
                        end
                    end else begin
                        r_hc <= r_hc + 1'b1;
                    end
                end

                c_ST_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_cmd_master
//  Purpose  : Self-checking bench for spi_cmd_master. Two instances run side
//             by side (CLK_DIV=4 and CLK_DIV=1), each attached to a simple
//             behavioural SPI slave that records mosi and returns a chosen
//             24-bit miso pattern.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_cmd_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [1:0] start = 2'b00;
    logic [1:0] rw_i  = 2'b00;
    logic [6:0] addr_i  [2];
    logic [7:0] wdata_i [2];
    logic [1:0] busy;
    logic [1:0] done;
    logic [7:0] rdata   [2];
    logic [1:0] sclk;
    logic [1:0] mosi;
    logic [1:0] cs;
    logic [1:0] miso = 2'b00;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model state (written only by the slave process).
    logic [23:0] resp [2];
    logic [23:0] cap  [2];
    int          cap_n  [2];
    int          rise_n [2];
    int          done_n [2];
    int          csf_n  [2];
    logic [1:0]  prev_cs   = 2'b11;
    logic [1:0]  prev_sclk = 2'b00;

    // Reference rdata per unit.
    logic [7:0]  exp_rdata [2];

    always #5 clk = ~clk;

    spi_cmd_master #(.CLK_DIV(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start[0]),
        .rw    (rw_i[0]),
        .addr  (addr_i[0]),
        .wdata (wdata_i[0]),
        .busy  (busy[0]),
        .done  (done[0]),
        .rdata (rdata[0]),
        .sclk  (sclk[0]),
        .mosi  (mosi[0]),
        .cs    (cs[0]),
        .miso  (miso[0])
    );

    spi_cmd_master #(.CLK_DIV(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start[1]),
        .rw    (rw_i[1]),
        .addr  (addr_i[1]),
        .wdata (wdata_i[1]),
        .busy  (busy[1]),
        .done  (done[1]),
        .rdata (rdata[1]),
        .sclk  (sclk[1]),
        .mosi  (mosi[1]),
        .cs    (cs[1]),
        .miso  (miso[1])
    );

    // Behavioural slave: new miso bit after each sclk rise, mosi recorded
    // after each sclk fall, cs falls and done pulses counted.
    initial begin
        for (int u = 0; u < 2; u++) begin
            cap[u] = '0; cap_n[u] = 0; rise_n[u] = 0; done_n[u] = 0; csf_n[u] = 0;
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (prev_cs[u] && !cs[u]) begin
                csf_n[u]++;
                cap[u]    = '0;
                cap_n[u]  = 0;
                rise_n[u] = 0;
            end
            if (!prev_sclk[u] && sclk[u]) begin
                if (rise_n[u] < 24) miso[u] = resp[u][23 - rise_n[u]];
                rise_n[u]++;
            end
            if (prev_sclk[u] && !sclk[u]) begin
                cap[u] = {cap[u][22:0], mosi[u]};
                cap_n[u]++;
            end
            if (done[u]) done_n[u]++;
            prev_cs[u]   = cs[u];
            prev_sclk[u] = sclk[u];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int div_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    function automatic logic [23:0] frame_of(input logic r, input logic [6:0] a, input logic [7:0] w);
        return r ? {1'b1, a, 16'h0000} : {8'h00, 1'b0, a, w};
    endfunction

    task automatic wait_idle(input int u);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (busy[u] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy[u]) check("idle_timeout", 0, 1);
    endtask

    // One complete frame with the slave returning {junk16, data}.
    task automatic run_frame(input int u, input logic r, input logic [6:0] a,
                             input logic [7:0] w, input logic [7:0] data, input bit mid_pulse);
        int          d, nb, k, bound, d0, f0;
        bit          got;
        logic [15:0] junk;
        d     = div_of(u);
        nb    = r ? 24 : 16;
        bound = 1 + d * (2 * nb + 2) + 20;
        junk  = 16'($urandom);
        resp[u] = {junk, data};
        wait_idle(u);
        d0 = done_n[u];
        f0 = csf_n[u];
        rw_i[u] = r; addr_i[u] = a; wdata_i[u] = w;
        start[u] = 1'b1;
        @(posedge clk); #1;
        check("busy_after_accept", 32'(busy[u]), 1);
        got = 0;
        for (k = 1; k <= bound; k++) begin
            start[u] = (mid_pulse && k == 20);
            @(posedge clk); #1;
            if (done[u]) begin got = 1; break; end
        end
        start[u] = 1'b0;
        if (!got) begin
            check("done_timeout", 0, 1);
        end else begin
            check("latency", k + 1, 1 + d * (2 * nb + 2));
            check("cs_at_done", 32'(cs[u]), 1);
            check("sclk_at_done", 32'(sclk[u]), 0);
            check("mosi_at_done", 32'(mosi[u]), 0);
            if (r) exp_rdata[u] = data;
            check("rdata", 32'(rdata[u]), 32'(exp_rdata[u]));
        end
        check("mosi_bits", cap_n[u], nb);
        check("mosi_frame", 32'(cap[u]), 32'(frame_of(r, a, w)));
        repeat (2 * d + 3) @(posedge clk);
        #1;
        check("busy_end", 32'(busy[u]), 0);
        check("done_count", done_n[u] - d0, 1);
        check("cs_low_count", csf_n[u] - f0, 1);
    endtask

    task automatic back_to_back;
        int          d0, f0, n, dones, gap;
        bit          counting;
        logic [6:0]  a;
        logic [7:0]  w;
        a = 7'($urandom); w = 8'($urandom);
        resp[0] = 24'($urandom);
        wait_idle(0);
        d0 = done_n[0]; f0 = csf_n[0];
        rw_i[0] = 1'b0; addr_i[0] = a; wdata_i[0] = w;
        start[0] = 1'b1;
        dones = 0; gap = 0; counting = 0; n = 0;
        while (dones < 2 && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (done[0]) begin
                dones++;
                if (dones == 1) counting = 1;
                else start[0] = 1'b0;
            end
            if (counting) begin
                if (cs[0]) gap++;
                else counting = 0;
            end
        end
        start[0] = 1'b0;
        check("b2b_two_done", dones, 2);
        check("b2b_gap", gap, 2 * 4 + 1);
        check("b2b_frame2", 32'(cap[0]), 32'(frame_of(1'b0, a, w)));
        repeat (12) @(posedge clk);
        #1;
        check("b2b_done_count", done_n[0] - d0, 2);
        check("b2b_cs_low_count", csf_n[0] - f0, 2);
        check("b2b_busy_end", 32'(busy[0]), 0);
    endtask

    task automatic reset_mid_frame;
        int n, d0;
        resp[0] = 24'($urandom);
        wait_idle(0);
        d0 = done_n[0];
        rw_i[0] = 1'b1; addr_i[0] = 7'($urandom); wdata_i[0] = 8'h00;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        n = 0;
        while (!(rise_n[0] == 11 && sclk[0]) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_bit10", rise_n[0], 11);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_cs", 32'(cs[0]), 1);
        check("rstmid_sclk", 32'(sclk[0]), 0);
        check("rstmid_busy", 32'(busy[0]), 0);
        check("rstmid_done", 32'(done[0]), 0);
        check("rstmid_rdata", 32'(rdata[0]), 0);
        rst = 1'b0;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        repeat (40) @(posedge clk);
        #1;
        check("rstmid_no_done", done_n[0] - d0, 0);
        check("rstmid_idle_cs", 32'(cs[0]), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            addr_i[u] = '0; wdata_i[u] = '0; resp[u] = '0; exp_rdata[u] = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("rst_cs", 32'(cs[u]), 1);
            check("rst_sclk", 32'(sclk[u]), 0);
            check("rst_mosi", 32'(mosi[u]), 0);
            check("rst_busy", 32'(busy[u]), 0);
            check("rst_done", 32'(done[u]), 0);
            check("rst_rdata", 32'(rdata[u]), 0);
        end
        rst = 1'b0;

        // Directed cases.
        run_frame(0, 1'b0, 7'h05, 8'hA5, 8'h00, 1'b0);
        run_frame(0, 1'b1, 7'h00, 8'h00, 8'h96, 1'b0);
        run_frame(1, 1'b1, 7'h2A, 8'h00, 8'h3C, 1'b0);
        // Start pulse while busy must be ignored.
        run_frame(0, 1'b0, 7'h11, 8'h5A, 8'h00, 1'b1);
        back_to_back();
        reset_mid_frame();
        run_frame(0, 1'b1, 7'h7F, 8'h00, 8'hC3, 1'b0);

        // Randomised frames on both units.
        for (int i = 0; i < 10; i++) begin
            run_frame(i % 2, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom),
                      8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
